rib_bus_arbiter: RTL and testbench

Arbitrates between three bus masters for one shared memory/peripheral slave port: core data access (m0), core instruction fetch (m1) and debug loader (m2). It sits between the core/debug masters and the ROM/RAM interconnect of tinyriscv_soc_top. Grants are round-robin and transaction-level: a grant is held until the slave acknowledges. A watchdog terminates hung transactions with an error response.

---
 rtl/rib_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_rib_bus_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_bus_arbiter.sv
// Three-master round-robin arbiter for a single slave port.
// A grant is held for the entire transaction, which ends in one of two ways:
// the slave acknowledges, or the watchdog completes it with an error.
// Handshake: a master holds req high until its one-cycle ack pulse. The
// slave sees s_req high for the whole BUSY window. The slave finishes with a
// one-cycle s_ack, and s_rdata must be valid in that same cycle.
module rib_bus_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic          m0_err,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic          m1_err,
   output logic [DW-1:0] m1_rdata,
   input  logic          m2_req,
   input  logic          m2_we,
   input  logic [AW-1:0] m2_addr,
   input  logic [DW-1:0] m2_wdata,
   output logic          m2_ack,
   output logic          m2_err,
   output logic [DW-1:0] m2_rdata,
   output logic          s_req,
   output logic          s_we,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   input  logic          s_ack,
   input  logic [DW-1:0] s_rdata,
   output logic [1:0]    grant,
   output logic          fsm_state
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [1:0]      last_grant;
   logic [1:0]      sel;
   logic            any_req;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic [CW-1:0]   counter;
   logic            timeout_hit;
   logic            done;

   assign fsm_state   = (state == BUSY);
   assign any_req     = (sel != 2'd3);
   // A slave ack in the last allowed cycle takes priority over the watchdog.
   assign timeout_hit = (state == BUSY) && !s_ack && (counter == CW'(TIMEOUT - 1));
   assign done        = (state == BUSY) && (s_ack || timeout_hit);

   // Round-robin pick: search starts at the master after the last owner.
   always_comb begin
      sel = 2'd3;
      case (last_grant)
         2'd0: begin
            if (m1_req)      sel = 2'd1;
            else if (m2_req) sel = 2'd2;
            else if (m0_req) sel = 2'd0;
         end
         2'd1: begin
            if (m2_req)      sel = 2'd2;
            else if (m0_req) sel = 2'd0;
            else if (m1_req) sel = 2'd1;
         end
         default: begin
            if (m0_req)      sel = 2'd0;
            else if (m1_req) sel = 2'd1;
            else if (m2_req) sel = 2'd2;
         end
      endcase
   end

   // Route the selected master's command fields toward the latch.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      case (sel)
         2'd0: begin sel_we = m0_we; sel_addr = m0_addr; sel_wdata = m0_wdata; end
         2'd1: begin sel_we = m1_we; sel_addr = m1_addr; sel_wdata = m1_wdata; end
         2'd2: begin sel_we = m2_we; sel_addr = m2_addr; sel_wdata = m2_wdata; end
         default: ;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next state: after each completion, always return through IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = BUSY;
         BUSY:    if (done)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: grant and command latch, watchdog count, registered response pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_req      <= 1'b0;
         s_we       <= 1'b0;
         s_addr     <= '0;
         s_wdata    <= '0;
         grant      <= 2'd3;
         last_grant <= 2'd2;
         counter    <= '0;
         m0_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m0_rdata   <= '0;
         m1_ack     <= 1'b0;
         m1_err     <= 1'b0;
         m1_rdata   <= '0;
         m2_ack     <= 1'b0;
         m2_err     <= 1'b0;
         m2_rdata   <= '0;
      end else begin
         m0_ack   <= 1'b0;
         m0_err   <= 1'b0;
         m0_rdata <= '0;
         m1_ack   <= 1'b0;
         m1_err   <= 1'b0;
         m1_rdata <= '0;
         m2_ack   <= 1'b0;
         m2_err   <= 1'b0;
         m2_rdata <= '0;
         if (state == IDLE) begin
            if (any_req) begin
               grant      <= sel;
               last_grant <= sel;
               s_we       <= sel_we;
               s_addr     <= sel_addr;
               s_wdata    <= sel_wdata;
               s_req      <= 1'b1;
               counter    <= '0;
            end
         end else begin
            counter <= counter + 1'b1;
            if (done) begin
               s_req <= 1'b0;
               grant <= 2'd3;
               case (grant)
                  2'd0: begin
                     m0_ack   <= 1'b1;
                     m0_err   <= !s_ack;
                     m0_rdata <= s_ack ? s_rdata : '0;
                  end
                  2'd1: begin
                     m1_ack   <= 1'b1;
                     m1_err   <= !s_ack;
                     m1_rdata <= s_ack ? s_rdata : '0;
                  end
                  2'd2: begin
                     m2_ack   <= 1'b1;
                     m2_err   <= !s_ack;
                     m2_rdata <= s_ack ? s_rdata : '0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_rib_bus_arbiter.sv
// Bench for rib_bus_arbiter. It runs directed scenarios first and then a
// randomized run that is checked against a round-robin transaction model.
module tb_rib_bus_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int T  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m1_req, m1_we, m2_req, m2_we;
   logic [AW-1:0] m0_addr, m1_addr, m2_addr;
   logic [DW-1:0] m0_wdata, m1_wdata, m2_wdata;
   logic          m0_ack, m0_err, m1_ack, m1_err, m2_ack, m2_err;
   logic [DW-1:0] m0_rdata, m1_rdata, m2_rdata;
   logic          s_req, s_we, s_ack;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata, s_rdata;
   logic [1:0]    grant;
   logic          fsm_state;

   logic [2:0]    acks, errs;
   logic [DW-1:0] rd_out [3];

   int total = 0;
   int bad   = 0;

   assign acks = {m2_ack, m1_ack, m0_ack};
   assign errs = {m2_err, m1_err, m0_err};
   assign rd_out[0] = m0_rdata;
   assign rd_out[1] = m1_rdata;
   assign rd_out[2] = m2_rdata;

   rib_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .m2_req(m2_req), .m2_we(m2_we), .m2_addr(m2_addr), .m2_wdata(m2_wdata),
      .m2_ack(m2_ack), .m2_err(m2_err), .m2_rdata(m2_rdata),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_ack(s_ack), .s_rdata(s_rdata), .grant(grant), .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_reqs(input logic [2:0] r);
      m0_req = r[0];
      m1_req = r[1];
      m2_req = r[2];
   endtask

   task automatic drive_m(input int m, input logic rq, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      case (m)
         0: begin m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = d; end
         1: begin m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = d; end
         default: begin m2_req = rq; m2_we = we; m2_addr = a; m2_wdata = d; end
      endcase
   endtask

   task automatic idle_inputs();
      for (int m = 0; m < 3; m++) drive_m(m, 1'b0, 1'b0, '0, '0);
      s_ack   = 1'b0;
      s_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      m0_req = 1'b1;
      tick();
      tick();
      total++; if (grant !== 2'd3) begin bad++; $display("FAIL reset_grant got=%0d exp=3", grant); end
      total++; if (s_req !== 1'b0 || s_we !== 1'b0) begin bad++; $display("FAIL reset_sreq got=%b/%b exp=0/0", s_req, s_we); end
      total++; if (s_addr !== '0 || s_wdata !== '0) begin bad++; $display("FAIL reset_sbus got=%h/%h exp=0/0", s_addr, s_wdata); end
      total++; if (acks !== 3'b000 || errs !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b/%b exp=000/000", acks, errs); end
      total++; if ((m0_rdata | m1_rdata | m2_rdata) !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", m0_rdata | m1_rdata | m2_rdata); end
      total++; if (fsm_state !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", fsm_state); end
      rst = 1'b0;
      m0_req = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      drive_m(0, 1'b1, 1'b0, 32'h100, '0);
      tick();
      total++; if (grant !== 2'd0 || s_req !== 1'b1) begin bad++; $display("FAIL read_grant got=%0d/%b exp=0/1", grant, s_req); end
      total++; if (s_addr !== 32'h100 || s_we !== 1'b0) begin bad++; $display("FAIL read_cmd got=%h/%b exp=100/0", s_addr, s_we); end
      tick();
      tick();
      total++; if (acks !== 3'b000) begin bad++; $display("FAIL read_early_ack got=%b exp=000", acks); end
      s_ack = 1'b1;
      s_rdata = 32'hDEADBEEF;
      tick();
      total++; if (acks !== 3'b001 || m0_err !== 1'b0) begin bad++; $display("FAIL read_ack got=%b/%b exp=001/0", acks, m0_err); end
      total++; if (m0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rdata got=%h exp=deadbeef", m0_rdata); end
      total++; if (grant !== 2'd3 || s_req !== 1'b0) begin bad++; $display("FAIL read_release got=%0d/%b exp=3/0", grant, s_req); end
      s_ack = 1'b0;
      s_rdata = '0;
      m0_req = 1'b0;
      tick();
      total++; if (acks !== 3'b000 || m0_rdata !== '0) begin bad++; $display("FAIL read_pulse got=%b/%h exp=000/0", acks, m0_rdata); end
   endtask

   task automatic test_contention();
      int         order [6] = '{0, 1, 2, 0, 2, 0};
      logic [2:0] active = 3'b111;
      do_reset();
      set_reqs(3'b111);
      for (int i = 0; i < 6; i++) begin
         tick();
         total++; if (grant !== 2'(order[i]) || s_req !== 1'b1) begin bad++; $display("FAIL contend_grant%0d got=%0d exp=%0d", i, grant, order[i]); end
         set_reqs(active);
         tick();
         s_ack = 1'b1;
         s_rdata = 32'hA0 + i;
         tick();
         total++; if (acks !== (3'b001 << order[i])) begin bad++; $display("FAIL contend_ack%0d got=%b exp=%b", i, acks, 3'b001 << order[i]); end
         total++; if (grant !== 2'd3) begin bad++; $display("FAIL contend_idle%0d got=%0d exp=3", i, grant); end
         s_ack = 1'b0;
         if (i == 2) active = 3'b101;
         set_reqs(i == 5 ? 3'b000 : (active & ~(3'b001 << order[i])));
      end
      tick();
      total++; if (grant !== 2'd3) begin bad++; $display("FAIL contend_end got=%0d exp=3", grant); end
   endtask

   task automatic test_write();
      drive_m(2, 1'b1, 1'b1, 32'h2000_0004, 32'h1234_5678);
      tick();
      total++; if (grant !== 2'd2 || s_we !== 1'b1) begin bad++; $display("FAIL write_grant got=%0d/%b exp=2/1", grant, s_we); end
      total++; if (s_addr !== 32'h2000_0004 || s_wdata !== 32'h1234_5678) begin bad++; $display("FAIL write_cmd got=%h/%h exp=20000004/12345678", s_addr, s_wdata); end
      drive_m(2, 1'b1, 1'b0, '0, 32'hFFFF_FFFF);
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (s_we !== 1'b1 || s_wdata !== 32'h1234_5678 || s_addr !== 32'h2000_0004) begin
            bad++; $display("FAIL write_frozen%0d got=%b/%h/%h exp=1/12345678/20000004", k, s_we, s_wdata, s_addr);
         end
      end
      s_ack = 1'b1;
      tick();
      total++; if (acks !== 3'b100 || m2_err !== 1'b0) begin bad++; $display("FAIL write_ack got=%b/%b exp=100/0", acks, m2_err); end
      s_ack = 1'b0;
      drive_m(2, 1'b0, 1'b0, '0, '0);
      tick();
   endtask

   task automatic test_timeout();
      drive_m(1, 1'b1, 1'b0, 32'h300, '0);
      s_rdata = 32'h5555_AAAA;
      tick();
      total++; if (grant !== 2'd1 || s_req !== 1'b1) begin bad++; $display("FAIL tmo_grant got=%0d/%b exp=1/1", grant, s_req); end
      for (int k = 1; k < T; k++) begin
         tick();
         total++; if (acks !== 3'b000 || s_req !== 1'b1) begin bad++; $display("FAIL tmo_wait%0d got=%b/%b exp=000/1", k, acks, s_req); end
      end
      tick();
      total++; if (acks !== 3'b010 || m1_err !== 1'b1) begin bad++; $display("FAIL tmo_ack got=%b/%b exp=010/1", acks, m1_err); end
      total++; if (m1_rdata !== '0 || grant !== 2'd3 || s_req !== 1'b0) begin bad++; $display("FAIL tmo_release got=%h/%0d/%b exp=0/3/0", m1_rdata, grant, s_req); end
      m1_req = 1'b0;
      drive_m(0, 1'b1, 1'b0, 32'h40, '0);
      tick();
      total++; if (grant !== 2'd0) begin bad++; $display("FAIL tmo_next_grant got=%0d exp=0", grant); end
      s_ack = 1'b1;
      s_rdata = 32'h0BAD_F00D;
      tick();
      total++; if (acks !== 3'b001 || m0_err !== 1'b0 || m0_rdata !== 32'h0BAD_F00D) begin
         bad++; $display("FAIL tmo_next_ack got=%b/%b/%h exp=001/0/0badf00d", acks, m0_err, m0_rdata);
      end
      s_ack = 1'b0;
      m0_req = 1'b0;
      tick();
   endtask

   task automatic test_boundary();
      drive_m(0, 1'b1, 1'b0, 32'h80, '0);
      tick();
      total++; if (grant !== 2'd0) begin bad++; $display("FAIL bound_grant got=%0d exp=0", grant); end
      for (int k = 1; k < T; k++) tick();
      s_ack = 1'b1;
      s_rdata = 32'hCAFE_0001;
      tick();
      total++; if (acks !== 3'b001 || errs !== 3'b000 || m0_rdata !== 32'hCAFE_0001) begin
         bad++; $display("FAIL bound_ack got=%b/%b/%h exp=001/000/cafe0001", acks, errs, m0_rdata);
      end
      s_ack = 1'b0;
      m0_req = 1'b0;
      tick();
      s_ack = 1'b1;
      s_rdata = 32'h1234;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (acks !== 3'b000 || grant !== 2'd3 || s_req !== 1'b0) begin
            bad++; $display("FAIL spurious%0d got=%b/%0d/%b exp=000/3/0", k, acks, grant, s_req);
         end
      end
      s_ack = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      drive_m(1, 1'b1, 1'b0, 32'h500, '0);
      tick();
      total++; if (grant !== 2'd1) begin bad++; $display("FAIL rmid_grant got=%0d exp=1", grant); end
      tick();
      tick();
      rst = 1'b1;
      s_ack = 1'b1;
      s_rdata = 32'h7777;
      tick();
      total++; if (s_req !== 1'b0 || grant !== 2'd3 || acks !== 3'b000 || fsm_state !== 1'b0) begin
         bad++; $display("FAIL rmid_abort got=%b/%0d/%b/%b exp=0/3/000/0", s_req, grant, acks, fsm_state);
      end
      rst = 1'b0;
      s_ack = 1'b0;
      set_reqs(3'b111);
      tick();
      total++; if (grant !== 2'd0 || acks !== 3'b000) begin bad++; $display("FAIL rmid_first got=%0d/%b exp=0/000", grant, acks); end
      s_ack = 1'b1;
      tick();
      total++; if (acks !== 3'b001) begin bad++; $display("FAIL rmid_ack got=%b exp=001", acks); end
      s_ack = 1'b0;
      set_reqs(3'b000);
      tick();
   endtask

   // Randomized traffic against a transaction-level round-robin model.
   task automatic test_random(input int ncyc);
      bit            wants [3];
      bit            just_acked [3];
      logic [AW-1:0] a [3];
      logic          w [3];
      logic [DW-1:0] d [3];
      logic [2:0]    in_req;
      logic          in_ack;
      logic [DW-1:0] in_rdata;
      int            owner, last, cyc, sdelay, m;
      logic [AW-1:0] la;
      logic          lwe;
      logic [DW-1:0] lwd;
      logic [2:0]    e_ack, e_err;
      logic [DW-1:0] e_rd [3];
      logic [1:0]    e_grant;
      logic          e_sreq;
      logic [DW-1:0] exp_q [$];

      do_reset();
      owner = -1; last = 2; cyc = 0; sdelay = 0;
      la = '0; lwe = 1'b0; lwd = '0;
      for (int i = 0; i < 3; i++) begin
         wants[i] = 0; just_acked[i] = 0; a[i] = '0; w[i] = 1'b0; d[i] = '0;
      end
      for (int n = 0; n < ncyc && bad < 50; n++) begin
         // masters
         for (int i = 0; i < 3; i++) begin
            if (wants[i]) begin
               if (owner == i && $urandom_range(0, 7) == 0)
                  drive_m(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
               else if (owner != i)
                  drive_m(i, 1'b1, w[i], a[i], d[i]);
            end else if (!just_acked[i] && $urandom_range(0, 2) == 0) begin
               wants[i] = 1;
               a[i] = $urandom;
               w[i] = 1'($urandom_range(0, 1));
               d[i] = $urandom;
               drive_m(i, 1'b1, w[i], a[i], d[i]);
            end else begin
               drive_m(i, 1'b0, 1'b0, '0, '0);
            end
            just_acked[i] = 0;
         end
         in_req = {m2_req, m1_req, m0_req};
         // slave
         in_ack   = (owner >= 0) ? (cyc == sdelay) : ($urandom_range(0, 9) == 0);
         in_rdata = $urandom;
         s_ack    = in_ack;
         s_rdata  = in_rdata;
         tick();
         // model: what the edge just taken must have produced
         e_ack = '0; e_err = '0; e_grant = 2'd3; e_sreq = 1'b0;
         for (int i = 0; i < 3; i++) e_rd[i] = '0;
         if (owner < 0) begin
            for (int k = 1; k <= 3; k++) begin
               m = (last + k) % 3;
               if (in_req[m]) begin owner = m; break; end
            end
            if (owner >= 0) begin
               last = owner; cyc = 0;
               la = a[owner]; lwe = w[owner]; lwd = d[owner];
               sdelay = $urandom_range(0, T + 3);
               e_grant = 2'(owner); e_sreq = 1'b1;
            end
         end else if (in_ack || cyc == T - 1) begin
            e_ack[owner] = 1'b1;
            e_err[owner] = !in_ack;
            e_rd[owner]  = in_ack ? in_rdata : '0;
            exp_q.push_back(e_rd[owner]);
            owner = -1;
         end else begin
            cyc++;
            e_grant = 2'(owner); e_sreq = 1'b1;
         end
         // compare
         total++; if (grant !== e_grant || s_req !== e_sreq) begin
            bad++; $display("FAIL rnd_grant c%0d got=%0d/%b exp=%0d/%b", n, grant, s_req, e_grant, e_sreq);
         end
         total++; if (acks !== e_ack || errs !== e_err) begin
            bad++; $display("FAIL rnd_ack c%0d got=%b/%b exp=%b/%b", n, acks, errs, e_ack, e_err);
         end
         for (int i = 0; i < 3; i++) begin
            total++; if (rd_out[i] !== e_rd[i]) begin
               bad++; $display("FAIL rnd_rdata%0d c%0d got=%h exp=%h", i, n, rd_out[i], e_rd[i]);
            end
         end
         if (e_sreq) begin
            total++; if (s_addr !== la || s_we !== lwe || s_wdata !== lwd) begin
               bad++; $display("FAIL rnd_cmd c%0d got=%h/%b/%h exp=%h/%b/%h", n, s_addr, s_we, s_wdata, la, lwe, lwd);
            end
         end
         // scoreboard: the response returned must match the one queued by the model
         for (int i = 0; i < 3; i++) begin
            if (acks[i] === 1'b1) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++; $display("FAIL rnd_sb c%0d got=%h exp=none", n, rd_out[i]);
               end else if (rd_out[i] !== exp_q[0]) begin
                  bad++; $display("FAIL rnd_sb c%0d got=%h exp=%h", n, rd_out[i], exp_q[0]);
               end
            end
         end
         exp_q.delete();
         for (int i = 0; i < 3; i++) begin
            if (e_ack[i]) begin wants[i] = 0; just_acked[i] = 1; end
         end
      end
      idle_inputs();
      tick();
      tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single_read();
      test_contention();
      test_write();
      test_timeout();
      test_boundary();
      test_reset_mid();
      test_random(3000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
